// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, control bundle layout.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  // ALU operation class carried in alu_type_sel
  localparam logic [1:0] ALUT_ALU   = 2'b00;
  localparam logic [1:0] ALUT_ADD   = 2'b01;
  localparam logic [1:0] ALUT_CMP   = 2'b10;
  localparam logic [1:0] ALUT_PASSB = 2'b11;

  // Control bundle, MSB first; packed order matches the ID/EX CTRL bit layout
  typedef struct packed {
    logic [1:0] alu_type_sel;
    logic [2:0] alucontrol;
    logic [6:0] alucontrol7;
    logic       b_imm_sel;
    logic       branch;
    logic       jump;
    logic       memwrite_en;
    logic       regwrite_en;
    logic       wb_sel;
  } ctrl_t;

  localparam int unsigned CTRL_W        = 18;
  localparam int unsigned CTRL_WB_SEL   = 0;
  localparam int unsigned CTRL_REGWRITE = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_JUMP     = 3;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_BIMM     = 5;
  localparam int unsigned CTRL_ALU7_LSB = 6;
  localparam int unsigned CTRL_ALUC_LSB = 13;
  localparam int unsigned CTRL_ALUT_LSB = 16;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// IF/ID, WB and ID/EX signal bundle around the decode stage.
interface id_ex_stage_if
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) ();
  localparam int unsigned AW = $clog2(NREGS);

  logic              IF_ID_valid;
  logic [31:0]       IF_ID_IR;
  logic [XLEN-1:0]   IF_ID_PC;
  logic              WB_ID_regwrite;
  logic [AW-1:0]     WB_ID_RDW_addr;
  logic [XLEN-1:0]   WB_ID_WD;
  logic              ex_flush;
  logic              stall_i;
  logic              id_stall;
  logic              ID_EX_valid;
  logic [XLEN-1:0]   ID_EX_PC;
  logic [XLEN-1:0]   ID_EX_A;
  logic [XLEN-1:0]   ID_EX_B;
  logic [XLEN-1:0]   ID_EX_IMM;
  logic [AW-1:0]     ID_EX_RD;
  logic [AW-1:0]     ID_EX_RS1;
  logic [AW-1:0]     ID_EX_RS2;
  logic [CTRL_W-1:0] ID_EX_CTRL;

  modport master (
    output IF_ID_valid, IF_ID_IR, IF_ID_PC, WB_ID_regwrite, WB_ID_RDW_addr, WB_ID_WD,
           ex_flush, stall_i,
    input  id_stall, ID_EX_valid, ID_EX_PC, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_RD,
           ID_EX_RS1, ID_EX_RS2, ID_EX_CTRL
  );

  modport slave (
    input  IF_ID_valid, IF_ID_IR, IF_ID_PC, WB_ID_regwrite, WB_ID_RDW_addr, WB_ID_WD,
           ex_flush, stall_i,
    output id_stall, ID_EX_valid, ID_EX_PC, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_RD,
           ID_EX_RS1, ID_EX_RS2, ID_EX_CTRL
  );
endinterface

// File: rtl/control_unit.sv
// Main decoder: opcode/funct fields to control bundle and immediate format.
module control_unit
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output imm_sel_e   imm_sel_o
);
  // Unknown opcodes fall through to an all-zero bundle, i.e. a NOP
  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    imm_sel_o = IMM_NONE;
    case (opcode_i)
      OP_REG: begin
        ctrl_o.alucontrol  = funct3_i;
        ctrl_o.alucontrol7 = funct7_i;
        ctrl_o.regwrite_en = 1'b1;
      end
      OP_IMM: begin
        ctrl_o.alucontrol  = funct3_i;
        ctrl_o.alucontrol7 = (funct3_i == 3'b001 || funct3_i == 3'b101) ? funct7_i : '0;
        ctrl_o.b_imm_sel   = 1'b1;
        ctrl_o.regwrite_en = 1'b1;
        imm_sel_o          = IMM_I;
      end
      OP_LOAD: begin
        ctrl_o.alu_type_sel = ALUT_ADD;
        ctrl_o.b_imm_sel    = 1'b1;
        ctrl_o.regwrite_en  = 1'b1;
        ctrl_o.wb_sel       = 1'b1;
        imm_sel_o           = IMM_I;
      end
      OP_STORE: begin
        ctrl_o.alu_type_sel = ALUT_ADD;
        ctrl_o.b_imm_sel    = 1'b1;
        ctrl_o.memwrite_en  = 1'b1;
        imm_sel_o           = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_o.alu_type_sel = ALUT_CMP;
        ctrl_o.alucontrol   = funct3_i;
        ctrl_o.branch       = 1'b1;
        imm_sel_o           = IMM_B;
      end
      OP_JAL, OP_JALR: begin
        ctrl_o.alu_type_sel = ALUT_ADD;
        ctrl_o.b_imm_sel    = 1'b1;
        ctrl_o.jump         = 1'b1;
        ctrl_o.regwrite_en  = 1'b1;
        imm_sel_o           = (opcode_i == OP_JAL) ? IMM_J : IMM_I;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_o.alu_type_sel = (opcode_i == OP_LUI) ? ALUT_PASSB : ALUT_ADD;
        ctrl_o.b_imm_sel    = 1'b1;
        ctrl_o.regwrite_en  = 1'b1;
        imm_sel_o           = IMM_U;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: rtl/id_ex_stage_hazard.sv
// Load-use detection against the instruction in ID/EX, and the IF hold request.
module id_hazard_unit #(
  parameter int unsigned AW = 5
) (
  input  logic          rst_i,
  input  logic          ex_flush_i,
  input  logic          stall_i,
  input  logic          if_id_valid_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic          id_ex_valid_i,
  input  logic          id_ex_wb_sel_i,
  input  logic          id_ex_regwrite_i,
  input  logic [AW-1:0] id_ex_rd_i,
  output logic          lu_o,
  output logic          id_stall_o
);
  // Both source fields are compared regardless of format; false stalls are harmless
  assign lu_o = id_ex_valid_i && id_ex_wb_sel_i && id_ex_regwrite_i && (id_ex_rd_i != '0)
             && ((id_ex_rd_i == rs1_i) || (id_ex_rd_i == rs2_i)) && if_id_valid_i;

  assign id_stall_o = !rst_i && !ex_flush_i && (stall_i || lu_o);
endmodule

// File: rtl/sign_extend.sv
// Immediate generator for the RV32I formats, sign-extended to XLEN.
module sign_extend
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     ir_i,
  input  imm_sel_e        imm_sel_i,
  output logic [XLEN-1:0] imm_o
);
  logic [31:0] imm32;

  // Reassemble the scattered immediate bits of each format
  always_comb begin
    case (imm_sel_i)
      IMM_I:   imm32 = {{20{ir_i[31]}}, ir_i[31:20]};
      IMM_S:   imm32 = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      IMM_B:   imm32 = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      IMM_U:   imm32 = {ir_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with register file and the ID/EX pipeline register.
module id_ex_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter bit          BYPASS_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] op_a, op_b, dec_imm;
  ctrl_t           dec_ctrl;
  imm_sel_e        dec_imm_sel;
  logic            lu, load_dp;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [AW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  ctrl_t           ctrl_q, ctrl_d;

  assign rs1 = AW'(bus.IF_ID_IR[19:15]);
  assign rs2 = AW'(bus.IF_ID_IR[24:20]);
  assign rd  = AW'(bus.IF_ID_IR[11:7]);

  control_unit u_ctrl (
    .opcode_i  (bus.IF_ID_IR[6:0]),
    .funct3_i  (bus.IF_ID_IR[14:12]),
    .funct7_i  (bus.IF_ID_IR[31:25]),
    .ctrl_o    (dec_ctrl),
    .imm_sel_o (dec_imm_sel)
  );

  sign_extend #(.XLEN(XLEN)) u_sext (
    .ir_i      (bus.IF_ID_IR[31:7]),
    .imm_sel_i (dec_imm_sel),
    .imm_o     (dec_imm)
  );

  id_hazard_unit #(.AW(AW)) u_hazard (
    .rst_i            (rst),
    .ex_flush_i       (bus.ex_flush),
    .stall_i          (bus.stall_i),
    .if_id_valid_i    (bus.IF_ID_valid),
    .rs1_i            (rs1),
    .rs2_i            (rs2),
    .id_ex_valid_i    (valid_q),
    .id_ex_wb_sel_i   (ctrl_q.wb_sel),
    .id_ex_regwrite_i (ctrl_q.regwrite_en),
    .id_ex_rd_i       (rd_q),
    .lu_o             (lu),
    .id_stall_o       (bus.id_stall)
  );

  // Register file write port; commits independently of ID/EX hold or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (bus.WB_ID_regwrite && bus.WB_ID_RDW_addr != '0) begin
      regs_q[bus.WB_ID_RDW_addr] <= bus.WB_ID_WD;
    end
  end

  // Operand A read: x0 forced to zero, optional same-cycle WB write-through
  always_comb begin
    op_a = regs_q[rs1];
    if (rs1 == '0) op_a = '0;
    else if (BYPASS_EN && bus.WB_ID_regwrite && bus.WB_ID_RDW_addr == rs1) op_a = bus.WB_ID_WD;
  end

  // Operand B read: same rules as operand A
  always_comb begin
    op_b = regs_q[rs2];
    if (rs2 == '0) op_b = '0;
    else if (BYPASS_EN && bus.WB_ID_regwrite && bus.WB_ID_RDW_addr == rs2) op_b = bus.WB_ID_WD;
  end

  // ID/EX next state: flush > stall (hold) > load-use bubble > normal load.
  // Bubbles still load the datapath fields; only valid and CTRL are cleared.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    load_dp = 1'b0;
    if (bus.ex_flush || (!bus.stall_i && lu)) begin
      load_dp = 1'b1;
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (!bus.stall_i) begin
      load_dp = 1'b1;
      valid_d = bus.IF_ID_valid;
      ctrl_d  = bus.IF_ID_valid ? dec_ctrl : CTRL_BUBBLE;
    end
    if (load_dp) begin
      pc_d  = bus.IF_ID_PC;
      a_d   = op_a;
      b_d   = op_b;
      imm_d = dec_imm;
      rd_d  = rd;
      rs1_d = rs1;
      rs2_d = rs2;
    end
  end

  // ID/EX pipeline register with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign bus.ID_EX_valid = valid_q;
  assign bus.ID_EX_CTRL  = ctrl_q;
  assign bus.ID_EX_PC    = pc_q;
  assign bus.ID_EX_A     = a_q;
  assign bus.ID_EX_B     = b_q;
  assign bus.ID_EX_IMM   = imm_q;
  assign bus.ID_EX_RD    = rd_q;
  assign bus.ID_EX_RS1   = rs1_q;
  assign bus.ID_EX_RS2   = rs2_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with write-through disabled
// sees the same stimulus.
module tb_id_ex_stage;
  import rv_pkg::*;

  localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD4 = 32'h0001_8233; // add  x4,x3,x0
  localparam logic [31:0] I_LW   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD6 = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] I_BEQ  = 32'h0020_8463; // beq  x1,x2,8
  localparam logic [31:0] I_SUB  = 32'h4020_83B3; // sub  x7,x1,x2
  localparam logic [31:0] I_ADD8 = 32'h0003_8433; // add  x8,x7,x0

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32), .NREGS(32)) bus0 ();
  id_ex_stage_if #(.XLEN(32), .NREGS(32)) bus1 ();

  assign bus1.IF_ID_valid    = bus0.IF_ID_valid;
  assign bus1.IF_ID_IR       = bus0.IF_ID_IR;
  assign bus1.IF_ID_PC       = bus0.IF_ID_PC;
  assign bus1.WB_ID_regwrite = bus0.WB_ID_regwrite;
  assign bus1.WB_ID_RDW_addr = bus0.WB_ID_RDW_addr;
  assign bus1.WB_ID_WD       = bus0.WB_ID_WD;
  assign bus1.ex_flush       = bus0.ex_flush;
  assign bus1.stall_i        = bus0.stall_i;

  id_ex_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  id_ex_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(1'b0)) u_dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    bus0.WB_ID_regwrite = we;
    bus0.WB_ID_RDW_addr = addr;
    bus0.WB_ID_WD       = data;
  endtask

  task automatic ifid(input logic [31:0] ir, input logic [31:0] pc);
    bus0.IF_ID_valid = 1'b1;
    bus0.IF_ID_IR    = ir;
    bus0.IF_ID_PC    = pc;
  endtask

  initial begin
    rst = 1'b1;
    bus0.ex_flush = 1'b0;
    bus0.stall_i  = 1'b1;
    ifid(I_ADDI, 32'h100);
    wb(1'b0, 5'd0, 32'h0);

    // Reset held two cycles
    #1;
    check("rst_idstall0", 32'(bus0.id_stall), 32'h0);
    tick();
    check("rst_valid", 32'(bus0.ID_EX_valid), 32'h0);
    check("rst_ctrl", 32'(bus0.ID_EX_CTRL), 32'h0);
    check("rst_imm", bus0.ID_EX_IMM, 32'h0);
    tick();
    check("rst_pc", bus0.ID_EX_PC, 32'h0);
    check("rst_rd", 32'(bus0.ID_EX_RD), 32'h0);
    check("rst_idstall1", 32'(bus0.id_stall), 32'h0);
    rst = 1'b0;
    bus0.stall_i = 1'b0;
    tick();
    check("addi_imm", bus0.ID_EX_IMM, 32'h5);
    check("addi_valid", 32'(bus0.ID_EX_valid), 32'h1);
    check("addi_ctrl", 32'(bus0.ID_EX_CTRL), 32'h22);
    check("addi_rd", 32'(bus0.ID_EX_RD), 32'h1);
    check("addi_pc", bus0.ID_EX_PC, 32'h100);

    // Write-through on x3
    ifid(I_ADD4, 32'h104);
    wb(1'b1, 5'd3, 32'hDEAD_BEEF);
    tick();
    check("wt_a_byp", bus0.ID_EX_A, 32'hDEAD_BEEF);
    check("wt_a_nobyp", bus1.ID_EX_A, 32'h0);
    check("add_ctrl", 32'(bus0.ID_EX_CTRL), 32'h2);
    check("add_rd", 32'(bus0.ID_EX_RD), 32'h4);

    // Write to x0 is discarded and never forwarded
    ifid(I_ADDI, 32'h108);
    wb(1'b1, 5'd0, 32'h1234_5678);
    tick();
    check("x0_byp", bus0.ID_EX_A, 32'h0);
    check("x0_nobyp", bus1.ID_EX_A, 32'h0);
    ifid(I_ADD4, 32'h10C);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    check("x3_stored", bus1.ID_EX_A, 32'hDEAD_BEEF);

    // Load-use: lw x5 then add using x5
    ifid(I_LW, 32'h110);
    tick();
    check("lw_ctrl", 32'(bus0.ID_EX_CTRL), 32'h1_0023);
    check("lw_rd", 32'(bus0.ID_EX_RD), 32'h5);
    ifid(I_ADD6, 32'h114);
    #1;
    check("lu_idstall", 32'(bus0.id_stall), 32'h1);
    tick();
    check("lu_bub_valid", 32'(bus0.ID_EX_valid), 32'h0);
    check("lu_bub_ctrl", 32'(bus0.ID_EX_CTRL), 32'h0);
    check("lu_idstall_off", 32'(bus0.id_stall), 32'h0);
    tick();
    check("lu_add_rs1", 32'(bus0.ID_EX_RS1), 32'h5);
    check("lu_add_rs2", 32'(bus0.ID_EX_RS2), 32'h2);
    check("lu_add_valid", 32'(bus0.ID_EX_valid), 32'h1);
    check("lu_add_ctrl", 32'(bus0.ID_EX_CTRL), 32'h2);

    // Flush with beq in ID
    ifid(I_BEQ, 32'h118);
    bus0.ex_flush = 1'b1;
    #1;
    check("fl_idstall", 32'(bus0.id_stall), 32'h0);
    tick();
    check("fl_valid", 32'(bus0.ID_EX_valid), 32'h0);
    check("fl_branch", 32'(bus0.ID_EX_CTRL[CTRL_BRANCH]), 32'h0);
    bus0.ex_flush = 1'b0;
    tick();
    check("beq_ctrl", 32'(bus0.ID_EX_CTRL), 32'h2_0010);
    check("beq_imm", bus0.ID_EX_IMM, 32'h8);
    check("beq_rd", 32'(bus0.ID_EX_RD), 32'h8);

    // Flush together with downstream stall: bubble is loaded
    ifid(I_SUB, 32'h200);
    bus0.ex_flush = 1'b1;
    bus0.stall_i  = 1'b1;
    #1;
    check("flst_idstall", 32'(bus0.id_stall), 32'h0);
    tick();
    check("flst_valid", 32'(bus0.ID_EX_valid), 32'h0);
    check("flst_ctrl", 32'(bus0.ID_EX_CTRL), 32'h0);
    check("flst_rd", 32'(bus0.ID_EX_RD), 32'h7);
    check("flst_pc", bus0.ID_EX_PC, 32'h200);

    // Downstream stall for three cycles with sub held in ID/EX
    bus0.ex_flush = 1'b0;
    bus0.stall_i  = 1'b0;
    ifid(I_SUB, 32'h204);
    tick();
    check("sub_ctrl", 32'(bus0.ID_EX_CTRL), 32'h802);
    ifid(I_ADD8, 32'h208);
    bus0.stall_i = 1'b1;
    wb(1'b1, 5'd7, 32'h0BAD_F00D);
    #1;
    check("st_idstall_in", 32'(bus0.id_stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      wb(1'b0, 5'd0, 32'h0);
      check("st_pc", bus0.ID_EX_PC, 32'h204);
      check("st_ctrl", 32'(bus0.ID_EX_CTRL), 32'h802);
      check("st_rd", 32'(bus0.ID_EX_RD), 32'h7);
      check("st_valid", 32'(bus0.ID_EX_valid), 32'h1);
      check("st_idstall", 32'(bus0.id_stall), 32'h1);
    end
    bus0.stall_i = 1'b0;
    tick();
    check("st_x7_byp", bus0.ID_EX_A, 32'h0BAD_F00D);
    check("st_x7_nobyp", bus1.ID_EX_A, 32'h0BAD_F00D);
    check("st_rd8", 32'(bus0.ID_EX_RD), 32'h8);

    // Reset while stall_i and load-use are both active
    ifid(I_LW, 32'h300);
    tick();
    ifid(I_ADD6, 32'h304);
    bus0.stall_i = 1'b1;
    #1;
    check("rs_idstall_pre", 32'(bus0.id_stall), 32'h1);
    rst = 1'b1;
    #1;
    check("rs_idstall", 32'(bus0.id_stall), 32'h0);
    tick();
    check("rs_valid", 32'(bus0.ID_EX_valid), 32'h0);
    check("rs_ctrl", 32'(bus0.ID_EX_CTRL), 32'h0);
    check("rs_pc", bus0.ID_EX_PC, 32'h0);
    check("rs_rd", 32'(bus0.ID_EX_RD), 32'h0);
    check("rs_rs1", 32'(bus0.ID_EX_RS1), 32'h0);
    rst = 1'b0;
    bus0.stall_i = 1'b0;
    ifid(I_ADD8, 32'h308);
    tick();
    check("rs_x7_cleared", bus1.ID_EX_A, 32'h0);
    check("rs_x7_cleared_b", bus0.ID_EX_A, 32'h0);
    check("rs_add_valid", 32'(bus0.ID_EX_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
